// File: rtl/lcd_page_fetch.sv
// Page-fetch sequencer: bursts one page of column bytes from a synchronous ROM
// into a local buffer, hands it to the LCD controller, then streams it bytewise.
module lcd_page_fetch #(
    parameter int ROM_LAT    = 1,
    parameter int PAGE_BYTES = 64,
    parameter int ADDR_W     = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            data_request,
    input  logic [ADDR_W-1:0]               addr,
    output logic                            data_ack,
    output logic [7:0]                      data,
    input  logic                            byte_next,
    output logic                            rom_rd,
    output logic [ADDR_W+$clog2(PAGE_BYTES)-1:0] rom_addr,
    input  logic [7:0]                      rom_data,
    output logic                            busy
);
    localparam int COL_W = $clog2(PAGE_BYTES);
    localparam logic [COL_W-1:0] LAST = COL_W'(PAGE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        ACK,
        STREAM
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [COL_W-1:0]   col_reg;
    logic [COL_W-1:0]   wr_idx_reg;
    logic [COL_W-1:0]   rd_idx_reg;
    logic [ROM_LAT-1:0] vld_reg;
    logic [7:0]         data_hold_reg;
    logic [7:0]         page_mem [PAGE_BYTES];
    logic               capture;

    // The top bit of the valid pipe marks the cycle rom_data belongs to a read.
    assign capture = vld_reg[ROM_LAT-1];

    always_comb begin
        state_next = state_reg;
        data_ack   = 1'b0;
        rom_rd     = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (data_request) state_next = FILL;
            end
            FILL: begin
                rom_rd = 1'b1;
                if (col_reg == LAST) state_next = DRAIN;
            end
            DRAIN: begin
                if (capture && wr_idx_reg == LAST) state_next = ACK;
            end
            ACK: begin
                data_ack = 1'b1;
                if (!data_request) state_next = STREAM;
            end
            STREAM: begin
                if (byte_next && rd_idx_reg == LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rom_addr = rom_rd ? {addr_reg, col_reg} : '0;

    always_comb begin
        case (state_reg)
            ACK:     data = page_mem[0];
            STREAM:  data = page_mem[rd_idx_reg];
            default: data = data_hold_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            col_reg       <= '0;
            wr_idx_reg    <= '0;
            rd_idx_reg    <= '0;
            vld_reg       <= '0;
            data_hold_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && data_request) begin
                addr_reg <= addr;
                col_reg  <= '0;
            end else if (rom_rd) begin
                col_reg <= col_reg + 1'b1;
            end
            vld_reg <= ROM_LAT'({vld_reg, rom_rd});
            if (capture) wr_idx_reg <= wr_idx_reg + 1'b1;
            if (state_reg == STREAM && byte_next) rd_idx_reg <= rd_idx_reg + 1'b1;
            // Outside ACK/STREAM the output keeps whatever byte was last presented.
            if (state_reg == ACK || state_reg == STREAM) data_hold_reg <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAGE_BYTES; i++) page_mem[i] <= '0;
        end else if (capture) begin
            page_mem[wr_idx_reg] <= rom_data;
        end
    end

endmodule

// File: tb/tb_lcd_page_fetch.sv
// Bench for lcd_page_fetch: two instances (ROM_LAT 1 and 3) with a ROM model
// returning the low byte of rom_addr, a table of transactions and a scoreboard.
`timescale 1ns/1ps
module tb_lcd_page_fetch;
    typedef struct {
        int         inst;
        logic [6:0] a;
        int         lat;
        logic [7:0] d0;
        int         hold;
        int         gap;
        logic       pre;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_s [2];
    logic        req_s   [2];
    logic [6:0]  addr_s  [2];
    logic        ack_s   [2];
    logic [7:0]  data_s  [2];
    logic        bn_s    [2];
    logic        rd_s    [2];
    logic [12:0] raddr_s [2];
    logic [7:0]  rdata_s [2];
    logic        busy_s  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [7:0] pipe [LAT];
        always @(posedge clk) begin
            pipe[0] <= rd_s[gi] ? raddr_s[gi][7:0] : 8'hEE;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign rdata_s[gi] = pipe[LAT-1];

        lcd_page_fetch #(.ROM_LAT(LAT), .PAGE_BYTES(64), .ADDR_W(7)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n_s[gi]),
            .data_request (req_s[gi]),
            .addr         (addr_s[gi]),
            .data_ack     (ack_s[gi]),
            .data         (data_s[gi]),
            .byte_next    (bn_s[gi]),
            .rom_rd       (rd_s[gi]),
            .rom_addr     (raddr_s[gi]),
            .rom_data     (rdata_s[gi]),
            .busy         (busy_s[gi])
        );
    end

    int total = 0;
    int bad   = 0;
    logic [12:0] q_addr [2][$];
    logic [7:0]  q_dat  [2][$];

    task automatic check(string name, int s, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, s, $time, act, exp);
        end
    endtask

    // Advance one clock and let the scoreboard consume any ROM read this cycle.
    task automatic tick();
        logic [12:0] ea;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (rd_s[s]) begin
                if (q_addr[s].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rom_rd_extra inst=%0d t=%0t got=%0h want=no_read", s, $time, raddr_s[s]);
                end else begin
                    ea = q_addr[s].pop_front();
                    check("rom_addr", s, 32'(raddr_s[s]), 32'(ea));
                end
            end
        end
    endtask

    task automatic request(int s, logic [6:0] a);
        addr_s[s] = a;
        req_s[s]  = 1'b1;
        for (int c = 0; c < 64; c++) begin
            q_addr[s].push_back({a, 6'(c)});
            q_dat[s].push_back({a[1:0], 6'(c)});
        end
    endtask

    task automatic check_idle_outputs(string name, int s, logic [7:0] d);
        check({name, "_ack"}, s, 32'(ack_s[s]), 32'd0);
        check({name, "_rd"}, s, 32'(rd_s[s]), 32'd0);
        check({name, "_raddr"}, s, 32'(raddr_s[s]), 32'd0);
        check({name, "_busy"}, s, 32'(busy_s[s]), 32'd0);
        check({name, "_data"}, s, 32'(data_s[s]), 32'(d));
    endtask

    task automatic run_txn(vec_t v, logic chain, logic [6:0] nxt);
        int s;
        int n;
        logic [7:0] ed;
        s  = v.inst;
        ed = 8'h00;
        n  = 0;
        if (v.pre) n = 1;
        else request(s, v.a);
        while (!ack_s[s] && n < 300) begin
            tick();
            n++;
            addr_s[s] = ~v.a;
        end
        check("ack_latency", s, 32'(n), 32'(v.lat));
        check("rd_count", s, 32'(q_addr[s].size()), 32'd0);
        check("ack_data", s, 32'(data_s[s]), 32'(v.d0));
        check("ack_busy", s, 32'(busy_s[s]), 32'd1);
        for (int h = 0; h < v.hold; h++) begin
            bn_s[s] = 1'(h % 2);
            tick();
            check("hold_ack", s, 32'(ack_s[s]), 32'd1);
            check("hold_data", s, 32'(data_s[s]), 32'(v.d0));
        end
        bn_s[s]  = 1'b0;
        req_s[s] = 1'b0;
        tick();
        check("ack_drop", s, 32'(ack_s[s]), 32'd0);
        for (int i = 0; i < 64; i++) begin
            ed = q_dat[s].pop_front();
            check("stream_data", s, 32'(data_s[s]), 32'(ed));
            check("stream_busy", s, 32'(busy_s[s]), 32'd1);
            bn_s[s] = 1'b1;
            if (i == 63 && chain) request(s, nxt);
            tick();
            bn_s[s] = 1'b0;
            if (i < 63) for (int g = 1; g < v.gap; g++) tick();
        end
        check("end_busy", s, 32'(busy_s[s]), 32'd0);
        check("end_ack", s, 32'(ack_s[s]), 32'd0);
        check("end_hold_data", s, 32'(data_s[s]), 32'(ed));
        $display("txn inst=%0d addr=%02h ack_latency=%0d first=%02h last=%02h", s, v.a, n, v.d0, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rows [4];
        vec_t fin;
        int   n;
        logic chain;
        logic [6:0] nxt;

        // inst, addr, ack latency, first byte, hold cycles, byte gap, raised by previous
        rows[0] = '{0, 7'h0B, 66, 8'hC0, 10, 2, 1'b0};
        rows[1] = '{0, 7'h0C, 67, 8'h00, 0,  1, 1'b1};
        rows[2] = '{1, 7'h0B, 68, 8'hC0, 3,  1, 1'b0};
        rows[3] = '{1, 7'h55, 68, 8'h40, 0,  3, 1'b0};
        fin     = '{1, 7'h21, 68, 8'h40, 2,  1, 1'b0};

        for (int s = 0; s < 2; s++) begin
            rst_n_s[s] = 1'b0;
            req_s[s]   = 1'b0;
            addr_s[s]  = 7'h00;
            bn_s[s]    = 1'b0;
        end
        repeat (3) tick();
        for (int s = 0; s < 2; s++) check_idle_outputs("reset", s, 8'h00);
        for (int s = 0; s < 2; s++) rst_n_s[s] = 1'b1;
        tick();
        for (int s = 0; s < 2; s++) check_idle_outputs("post_reset", s, 8'h00);

        for (int i = 0; i < 4; i++) begin
            chain = 1'b0;
            nxt   = 7'h00;
            if (i + 1 < 4) begin
                if (rows[i+1].pre && rows[i+1].inst == rows[i].inst) begin
                    chain = 1'b1;
                    nxt   = rows[i+1].a;
                end
            end
            run_txn(rows[i], chain, nxt);
        end

        // Abort a fill on the 3-cycle-latency instance after 20 reads.
        request(1, 7'h21);
        n = 0;
        while (q_addr[1].size() > 44 && n < 200) begin
            tick();
            n++;
        end
        check("reads_before_reset", 1, 32'(q_addr[1].size()), 32'd44);
        rst_n_s[1] = 1'b0;
        req_s[1]   = 1'b0;
        #1;
        check_idle_outputs("mid_fill_reset", 1, 8'h00);
        q_addr[1].delete();
        q_dat[1].delete();
        tick();
        rst_n_s[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_idle_outputs("after_abort", 1, 8'h00);
        end
        $display("txn inst=1 addr=21 aborted after 20 reads");
        run_txn(fin, 1'b0, 7'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_page_fetch.md
Name: lcd_page_fetch

Overview:
- Page-fetch sequencer between the picture ROM and the LCD panel controller.
- On a data_request for one {image, page} address, it bursts 64 column bytes from the synchronous ROM into a local page buffer and raises data_ack.
- It then streams the bytes to the LCD controller one per byte_next strobe.
- It owns the ROM read port and the four-phase request/acknowledge handshake.

Parameters:
- ROM_LAT, 1, ROM read latency in clk cycles (1..3); rom_data is valid ROM_LAT cycles after rom_rd.
- PAGE_BYTES, 64, bytes per page; must be a power of two.
- ADDR_W, 7, width of the page address {image[3:0], page[2:0]}.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- data_request  in  1  level request from the LCD controller
- addr  in  ADDR_W  page address; sampled only when a request is accepted
- data_ack  out  1  page buffer full and ready
- data  out  8  current stream byte
- byte_next  in  1  single-cycle pulse: consumer has used the current byte
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ADDR_W+6  ROM address {addr_l, col[5:0]}
- rom_data  in  8  ROM read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; all outputs 0.
  - Page buffer, column, write and read indices all cleared to 0.
- States: IDLE, FILL, DRAIN, ACK, STREAM.
- IDLE:
  - data_ack=0.
  - If data_request=1: latch addr into addr_l, col=0, go to FILL next cycle.
- FILL:
  - One rom_rd pulse per cycle, rom_addr={addr_l, col}, col incrementing 0..63.
  - After col=63 is issued, go to DRAIN.
  - rom_data is captured into buf[wr_idx] exactly ROM_LAT cycles after each rom_rd, via a ROM_LAT-deep valid shift pipe.
- DRAIN:
  - rom_rd=0.
  - Wait until the 64th byte is captured, then go to ACK.
  - First request to ACK takes 1+64+ROM_LAT cycles (66 with ROM_LAT=1).
- ACK:
  - data_ack=1, data=buf[0].
  - Hold until data_request=0, then go to STREAM with data_ack=0 on the next cycle.
  - byte_next is ignored in ACK.
- STREAM:
  - data=buf[rd_idx], combinational from the buffer, zero latency.
  - Each byte_next increments rd_idx.
  - On byte_next with rd_idx=63: rd_idx wraps to 0, go to IDLE.
- Request timing:
  - data_request is level-sensitive and only sampled in IDLE.
  - A request raised during FILL, DRAIN or STREAM is serviced on the first IDLE cycle, with no loss.
- addr is never re-sampled mid-transaction; changing addr after acceptance has no effect.
- byte_next outside STREAM is ignored. byte_next in consecutive cycles is legal: one byte per pulse.
- data outside STREAM/ACK holds the last driven value; it is 0 after reset.
- Reset mid-FILL or mid-STREAM aborts immediately:
  - No data_ack is issued.
  - In-flight ROM returns are discarded by clearing the valid pipe.
- rom_rd is never asserted outside FILL; there are exactly 64 rom_rd pulses per transaction.
- Width rules:
  - col, wr_idx and rd_idx are 6 bits and wrap naturally.
  - rom_addr = {addr_l, col}, with no arithmetic on addr_l.

Test Plan:
- Basic fetch, ROM_LAT=1, ROM model rom_data = low byte of rom_addr:
  - Request addr=7'h0B -> 64 rom_rd pulses, rom_addr 13'h2C0..13'h2FF.
  - data_ack rises 66 cycles after the request; data=8'hC0.
- Stream:
  - Drop request, then 64 byte_next pulses every 2 cycles -> data steps 8'hC0..8'hFF.
  - busy falls on the cycle after the 64th pulse.
- Handshake hold:
  - Keep data_request high for 10 cycles after data_ack -> data_ack stays 1 and data stays buf[0].
  - byte_next pulses during ACK do not advance data.
- Back-to-back:
  - Re-raise data_request with addr=7'h0C during the last STREAM byte.
  - -> The new FILL starts on the first IDLE cycle at rom_addr 13'h300; no byte of the previous page is skipped.
- Latency sweep, ROM_LAT=3:
  - Same request -> data_ack 68 cycles after the request.
  - buf[k] equals the rom_data of the k-th rom_rd for all k.
- Reset mid-FILL after 20 reads:
  - Pulse rst_n low -> all outputs 0, state IDLE, no data_ack.
  - Late ROM returns are not written.
  - A subsequent request completes normally.
